// File: rtl/stage_writeback_pkg.sv
// Shared widths and control-field positions for the write-back stage.
package stage_writeback_pkg;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned REG_CNT = 8;
    localparam int unsigned SEL_W   = 3;

    // Bit positions inside setValues
    localparam int unsigned SET_ACTIVE = 1;
    localparam int unsigned SET_COND   = 0;
endpackage

// File: rtl/wb_regfile.sv
// 8x16 architectural register file: one write port, two combinational read
// ports that forward the in-flight write value.
module wb_regfile
    import stage_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [SEL_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [SEL_W-1:0]  i_raddr1,
    input  logic [SEL_W-1:0]  i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);
    logic [DATA_W-1:0] r_regs [REG_CNT];
    logic              w_hit1;
    logic              w_hit2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_CNT); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Forwarding stays live during reset even though the write is dropped.
    assign w_hit1   = i_we && (i_raddr1 == i_waddr);
    assign w_hit2   = i_we && (i_raddr2 == i_waddr);
    assign o_rdata1 = w_hit1 ? i_wdata : r_regs[i_raddr1];
    assign o_rdata2 = w_hit2 ? i_wdata : r_regs[i_raddr2];
endmodule

// File: rtl/stage_writeback.sv
// Write-back stage: picks the retiring value (set flag, load data or ALU
// result), commits it to the register file and flags illegal controls.
module stage_writeback
    import stage_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] readData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [1:0]        setValues,
    input  logic              MemToReg,
    input  logic              writeEn,
    input  logic [SEL_W-1:0]  writeReg,
    output logic [DATA_W-1:0] writeData,
    input  logic [SEL_W-1:0]  readSel1,
    input  logic [SEL_W-1:0]  readSel2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              err
);
    logic [DATA_W-1:0] w_wb_data;

    // Set-class instructions take priority over the load/ALU select.
    always_comb begin
        w_wb_data = ALUResult;
        if (setValues[SET_ACTIVE]) begin
            w_wb_data = DATA_W'(setValues[SET_COND]);
        end else if (MemToReg) begin
            w_wb_data = readData;
        end
    end

    assign writeData = w_wb_data;
    assign err       = setValues[SET_ACTIVE] & MemToReg;

    wb_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (writeEn),
        .i_waddr  (writeReg),
        .i_wdata  (w_wb_data),
        .i_raddr1 (readSel1),
        .i_raddr2 (readSel2),
        .o_rdata1 (readData1),
        .o_rdata2 (readData2)
    );
endmodule

// File: tb/tb_stage_writeback.sv
// Directed vector table followed by randomized traffic against an array model.
module tb_stage_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] readData;
    logic [15:0] ALUResult;
    logic [1:0]  setValues;
    logic        MemToReg;
    logic        writeEn;
    logic [2:0]  writeReg;
    logic [15:0] writeData;
    logic [2:0]  readSel1;
    logic [2:0]  readSel2;
    logic [15:0] readData1;
    logic [15:0] readData2;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stage_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .readData  (readData),
        .ALUResult (ALUResult),
        .setValues (setValues),
        .MemToReg  (MemToReg),
        .writeEn   (writeEn),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readSel1  (readSel1),
        .readSel2  (readSel2),
        .readData1 (readData1),
        .readData2 (readData2),
        .err       (err)
    );

    typedef struct {
        logic        rst;
        logic [15:0] rdata;
        logic [15:0] alu;
        logic [1:0]  sv;
        logic        mtr;
        logic        we;
        logic [2:0]  wr;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [15:0] e_wd;
        logic [15:0] e_r1;
        logic [15:0] e_r2;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vec [NVEC];

    logic [15:0] model [8];

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [15:0] rd, input logic [15:0] alu,
                         input logic [1:0] sv, input logic mtr, input logic we,
                         input logic [2:0] wr, input logic [2:0] s1, input logic [2:0] s2);
        rst = r; readData = rd; ALUResult = alu; setValues = sv; MemToReg = mtr;
        writeEn = we; writeReg = wr; readSel1 = s1; readSel2 = s2;
    endtask

    initial begin
        logic [15:0] e_wd, e_r1, e_r2;
        logic        e_err;
        logic        r, mtr, we;
        logic [15:0] rd, alu;
        logic [1:0]  sv;
        logic [2:0]  wr, s1, s2;

        //          rst rdata    alu      sv     mtr  we   wr    s1    s2    wd       r1       r2       err
        vec[0]  = '{1, 16'h0000, 16'hBEEF, 2'b00, 0, 1, 3'd3, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 16'hBEEF, 0};
        vec[1]  = '{1, 16'h0000, 16'hBEEF, 2'b00, 0, 1, 3'd3, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 16'hBEEF, 0};
        vec[2]  = '{0, 16'h0000, 16'hBEEF, 2'b00, 0, 0, 3'd3, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 16'h0000, 0};
        vec[3]  = '{0, 16'h0000, 16'h0000, 2'b00, 0, 0, 3'd0, 3'd1, 3'd2, 16'h0000, 16'h0000, 16'h0000, 0};
        vec[4]  = '{0, 16'h0000, 16'h0000, 2'b00, 0, 0, 3'd0, 3'd4, 3'd5, 16'h0000, 16'h0000, 16'h0000, 0};
        vec[5]  = '{0, 16'h0000, 16'h0000, 2'b00, 0, 0, 3'd0, 3'd6, 3'd7, 16'h0000, 16'h0000, 16'h0000, 0};
        vec[6]  = '{0, 16'h0000, 16'h0000, 2'b00, 0, 0, 3'd0, 3'd3, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0};
        vec[7]  = '{0, 16'h0000, 16'h1234, 2'b00, 0, 1, 3'd5, 3'd5, 3'd7, 16'h1234, 16'h1234, 16'h0000, 0};
        vec[8]  = '{0, 16'h0000, 16'h1234, 2'b00, 0, 0, 3'd5, 3'd5, 3'd5, 16'h1234, 16'h1234, 16'h1234, 0};
        vec[9]  = '{0, 16'hA5A5, 16'h1234, 2'b00, 1, 1, 3'd7, 3'd7, 3'd5, 16'hA5A5, 16'hA5A5, 16'h1234, 0};
        vec[10] = '{0, 16'hFFFF, 16'h1234, 2'b00, 1, 0, 3'd7, 3'd7, 3'd5, 16'hFFFF, 16'hA5A5, 16'h1234, 0};
        vec[11] = '{0, 16'hFFFF, 16'h1234, 2'b00, 1, 0, 3'd7, 3'd7, 3'd7, 16'hFFFF, 16'hA5A5, 16'hA5A5, 0};
        vec[12] = '{0, 16'h0000, 16'hFFFF, 2'b11, 0, 1, 3'd2, 3'd7, 3'd2, 16'h0001, 16'hA5A5, 16'h0001, 0};
        vec[13] = '{0, 16'h0000, 16'hFFFF, 2'b10, 0, 1, 3'd2, 3'd2, 3'd7, 16'h0000, 16'h0000, 16'hA5A5, 0};
        vec[14] = '{0, 16'h0000, 16'h0042, 2'b00, 0, 0, 3'd2, 3'd2, 3'd5, 16'h0042, 16'h0000, 16'h1234, 0};
        vec[15] = '{0, 16'hFFFF, 16'h0042, 2'b11, 1, 0, 3'd2, 3'd2, 3'd7, 16'h0001, 16'h0000, 16'hA5A5, 1};
        vec[16] = '{0, 16'hFFFF, 16'h0042, 2'b11, 0, 0, 3'd2, 3'd2, 3'd7, 16'h0001, 16'h0000, 16'hA5A5, 0};
        vec[17] = '{0, 16'h0000, 16'h6666, 2'b00, 0, 1, 3'd6, 3'd6, 3'd6, 16'h6666, 16'h6666, 16'h6666, 0};
        vec[18] = '{0, 16'h0000, 16'h00C3, 2'b00, 0, 1, 3'd4, 3'd4, 3'd4, 16'h00C3, 16'h00C3, 16'h00C3, 0};
        vec[19] = '{0, 16'h0000, 16'h00C3, 2'b00, 0, 1, 3'd4, 3'd4, 3'd6, 16'h00C3, 16'h00C3, 16'h6666, 0};
        vec[20] = '{1, 16'h0000, 16'h7777, 2'b00, 0, 1, 3'd1, 3'd1, 3'd4, 16'h7777, 16'h7777, 16'h00C3, 0};
        vec[21] = '{0, 16'h0000, 16'h7777, 2'b00, 0, 0, 3'd1, 3'd1, 3'd4, 16'h7777, 16'h0000, 16'h0000, 0};

        drive(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, '0, '0, '0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vec[i].rst, vec[i].rdata, vec[i].alu, vec[i].sv, vec[i].mtr,
                  vec[i].we, vec[i].wr, vec[i].s1, vec[i].s2);
            #1;
            check16($sformatf("vec%0d writeData", i), writeData, vec[i].e_wd);
            check16($sformatf("vec%0d readData1", i), readData1, vec[i].e_r1);
            check16($sformatf("vec%0d readData2", i), readData2, vec[i].e_r2);
            check1 ($sformatf("vec%0d err", i),       err,       vec[i].e_err);
        end

        // Random traffic; the first cycle resets so the model starts from zero.
        for (int k = 0; k < 8; k++) model[k] = 16'h0000;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r   = (n == 0) || ($urandom_range(31) == 0);
            rd  = 16'($urandom);
            alu = 16'($urandom);
            sv  = 2'($urandom);
            mtr = 1'($urandom);
            we  = ($urandom_range(3) != 0);
            wr  = 3'($urandom);
            s1  = ($urandom_range(3) == 0) ? wr : 3'($urandom);
            s2  = ($urandom_range(3) == 0) ? s1 : 3'($urandom);
            drive(r, rd, alu, sv, mtr, we, wr, s1, s2);

            if (sv[1])   e_wd = {15'b0, sv[0]};
            else if (mtr) e_wd = rd;
            else          e_wd = alu;
            e_err = sv[1] && mtr;
            e_r1  = (we && s1 == wr) ? e_wd : model[s1];
            e_r2  = (we && s2 == wr) ? e_wd : model[s2];
            #1;
            check16("rand writeData", writeData, e_wd);
            check16("rand readData1", readData1, e_r1);
            check16("rand readData2", readData2, e_r2);
            check1 ("rand err",       err,       e_err);

            @(posedge clk);
            if (r) begin
                for (int k = 0; k < 8; k++) model[k] = 16'h0000;
            end else if (we) begin
                model[wr] = e_wd;
            end
        end

        // Final sweep of stored contents with writes disabled.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, '0, 3'(k), 3'(7 - k));
            #1;
            check16($sformatf("sweep r%0d", k),     readData1, model[k]);
            check16($sformatf("sweep r%0d", 7 - k), readData2, model[7 - k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
